// File: rtl/fetch_unpacker.sv
// Fetch unit: requests 64-bit lines, splits them into 32-bit instructions and queues them for decode.
// Optional FETCH_ILLEGAL_EN adds a per-entry instr_illegal flag (low two bits not 2'b11).
module fetch_unpacker #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        fetch_req,
  output logic [63:0] fetch_addr,
  input  logic        fetch_gnt,
  input  logic        rdata_valid,
  input  logic [63:0] rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_ILLEGAL_EN
  ,
  output logic        instr_illegal
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e            state_q, state_d;
  logic [63:2]       pc_q, pc_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, widx1;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       instr_mem [DEPTH];
  logic [63:2]       pc_mem    [DEPTH];
  logic              push0, push1, pop;
  logic [1:0]        n_push;
  logic              unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StReq;
      pc_q     <= RESET_PC[63:2];
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A response arriving together with a redirect still retires the outstanding request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq:   if (fetch_req && fetch_gnt) state_d = redirect ? StDrop : StWait;
      StWait:  begin
        if (rdata_valid)   state_d = StReq;
        else if (redirect) state_d = StDrop;
      end
      StDrop:  if (rdata_valid) state_d = StReq;
      default: state_d = StReq;
    endcase
  end

  always_comb begin
    fetch_req  = !reset && (state_q == StReq) && (count_q <= CntW'(DEPTH - 2));
    fetch_addr = {pc_q[63:3], 3'b000};
  end

  // Datapath next state: pushes only from a live response, redirect flushes everything.
  always_comb begin
    push1  = (state_q == StWait) && rdata_valid;
    push0  = push1 && !pc_q[2];
    pop    = instr_valid && instr_ready;
    n_push = {1'b0, push0} + {1'b0, push1};
    widx1  = push0 ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    if (redirect) begin
      pc_d     = redirect_pc[63:2];
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      pc_d     = push1 ? {pc_q[63:3] + 61'd1, 1'b0} : pc_q;
      wr_ptr_d = wr_ptr_q + PtrW'(n_push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(n_push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect) begin
      if (push0) begin
        instr_mem[wr_ptr_q] <= rdata[31:0];
        pc_mem[wr_ptr_q]    <= {pc_q[63:3], 1'b0};
      end
      if (push1) begin
        instr_mem[widx1] <= rdata[63:32];
        pc_mem[widx1]    <= {pc_q[63:3], 1'b1};
      end
    end
  end

  always_comb begin
    instr_valid = (count_q != '0);
    instr       = instr_valid ? instr_mem[rd_ptr_q] : 32'h0;
    instr_pc    = instr_valid ? {pc_mem[rd_ptr_q], 2'b00} : 64'h0;
  end

`ifdef FETCH_ILLEGAL_EN
  logic ill_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset && !redirect) begin
      if (push0) ill_mem[wr_ptr_q] <= (rdata[1:0] != 2'b11);
      if (push1) ill_mem[widx1]    <= (rdata[33:32] != 2'b11);
    end
  end

  assign instr_illegal = instr_valid && ill_mem[rd_ptr_q];
`endif

endmodule

// File: tb/tb_fetch_unpacker.sv
// Directed bench for fetch_unpacker (RESET_PC=0x1000, DEPTH=4); inputs change and outputs are
// sampled on the falling clock edge.
module tb_fetch_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        fetch_gnt = 1'b0;
  logic        rdata_valid = 1'b0;
  logic [63:0] rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef FETCH_ILLEGAL_EN
  logic        instr_illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unpacker #(
    .RESET_PC(64'h1000),
    .DEPTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
`ifdef FETCH_ILLEGAL_EN
    ,
    .instr_illegal(instr_illegal)
`endif
  );

  // Grant one line request now, return the response next cycle; returns after the push edge.
  task automatic serve_line(input logic [63:0] data);
    fetch_gnt = 1'b1;
    @(negedge clk);
    fetch_gnt   = 1'b0;
    rdata_valid = 1'b1;
    rdata       = data;
    @(negedge clk);
    rdata_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++; $display("FAIL reset_req_in_reset: got %b want 0", fetch_req);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_fifo: got v=%b i=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc);
    end
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 64'h1000) begin
      errors++; $display("FAIL reset_fetch: got req=%b addr=%h want 1/1000", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_basic;
    fetch_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++; $display("FAIL basic_wait_req: got %b want 0", fetch_req);
    end
    fetch_gnt   = 1'b0;
    rdata_valid = 1'b1;
    rdata       = 64'h00500093_00000013;
    @(negedge clk);
    rdata_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00000013 || instr_pc !== 64'h1000) begin
      errors++;
      $display("FAIL basic_word0: got v=%b i=%h pc=%h want 1/00000013/1000",
               instr_valid, instr, instr_pc);
    end
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 64'h1008) begin
      errors++; $display("FAIL basic_next_line: got req=%b addr=%h want 1/1008", fetch_req, fetch_addr);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00500093 || instr_pc !== 64'h1004) begin
      errors++;
      $display("FAIL basic_word1: got v=%b i=%h pc=%h want 1/00500093/1004",
               instr_valid, instr, instr_pc);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL basic_empty: got %b want 0", instr_valid);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_midline;
    redirect    = 1'b1;
    redirect_pc = 64'h2006;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 64'h2000) begin
      errors++; $display("FAIL redir_addr: got req=%b addr=%h want 1/2000", fetch_req, fetch_addr);
    end
    serve_line(64'h11111113_22222213);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h11111113 || instr_pc !== 64'h2004) begin
      errors++;
      $display("FAIL redir_upper: got v=%b i=%h pc=%h want 1/11111113/2004",
               instr_valid, instr, instr_pc);
    end
    checks++;
    if (fetch_addr !== 64'h2008) begin
      errors++; $display("FAIL redir_next_line: got %h want 2008", fetch_addr);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_single: got v=%b want 0", instr_valid);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] ew [4] = '{32'h0000a013, 32'h0000b013, 32'h0000c013, 32'h0000d013};
    logic [63:0] ep [4] = '{64'h2008, 64'h200c, 64'h2010, 64'h2014};
    serve_line(64'h0000b013_0000a013);
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 64'h2010) begin
      errors++; $display("FAIL bp_second_req: got req=%b addr=%h want 1/2010", fetch_req, fetch_addr);
    end
    serve_line(64'h0000d013_0000c013);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_req !== 1'b0 || instr !== 32'h0000a013 || instr_pc !== 64'h2008) begin
        errors++;
        $display("FAIL bp_full_hold[%0d]: got req=%b i=%h pc=%h want 0/0000a013/2008",
                 i, fetch_req, instr, instr_pc);
      end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== ew[i] || instr_pc !== ep[i]) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got v=%b i=%h pc=%h want 1/%h/%h",
                 i, instr_valid, instr, instr_pc, ew[i], ep[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drained: got %b want 0", instr_valid);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_wait;
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 64'h2018) begin
      errors++; $display("FAIL rw_pre: got req=%b addr=%h want 1/2018", fetch_req, fetch_addr);
    end
    fetch_gnt = 1'b1;
    @(negedge clk);
    fetch_gnt   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h3000;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++; $display("FAIL rw_drop_req: got %b want 0", fetch_req);
    end
    rdata_valid = 1'b1;
    rdata       = 64'h00000013_00000013;
    @(negedge clk);
    rdata_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || fetch_req !== 1'b1 || fetch_addr !== 64'h3000) begin
      errors++;
      $display("FAIL rw_dropped: got v=%b req=%b addr=%h want 0/1/3000",
               instr_valid, fetch_req, fetch_addr);
    end
  endtask

  task automatic test_push_pop;
    logic [31:0] ew [3] = '{32'h00000213, 32'h00000313, 32'h00000413};
    logic [63:0] ep [3] = '{64'h3004, 64'h3008, 64'h300c};
    serve_line(64'h00000213_00000113);
    checks++;
    if (instr !== 32'h00000113 || fetch_req !== 1'b1 || fetch_addr !== 64'h3008) begin
      errors++;
      $display("FAIL pp_pre: got i=%h req=%b addr=%h want 00000113/1/3008",
               instr, fetch_req, fetch_addr);
    end
    fetch_gnt = 1'b1;
    @(negedge clk);
    fetch_gnt   = 1'b0;
    rdata_valid = 1'b1;
    rdata       = 64'h00000413_00000313;
    instr_ready = 1'b1;
    @(negedge clk);
    rdata_valid = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++; $display("FAIL pp_count3_req: got %b want 0", fetch_req);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== ew[i] || instr_pc !== ep[i]) begin
        errors++;
        $display("FAIL pp_order[%0d]: got v=%b i=%h pc=%h want 1/%h/%h",
                 i, instr_valid, instr, instr_pc, ew[i], ep[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL pp_empty: got %b want 0", instr_valid);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    fetch_gnt = 1'b1;
    @(negedge clk);
    fetch_gnt = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    rdata_valid = 1'b1;
    rdata       = 64'h00000093_00000093;
    @(negedge clk);
    rdata_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || fetch_req !== 1'b1 || fetch_addr !== 64'h1000) begin
      errors++;
      $display("FAIL rst_wait: got v=%b req=%b addr=%h want 0/1/1000",
               instr_valid, fetch_req, fetch_addr);
    end
  endtask

`ifdef FETCH_ILLEGAL_EN
  task automatic test_illegal;
    serve_line(64'h00000013_00000001);
    checks++;
    if (instr !== 32'h00000001 || instr_illegal !== 1'b1) begin
      errors++; $display("FAIL ill_word0: got i=%h ill=%b want 00000001/1", instr, instr_illegal);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (instr !== 32'h00000013 || instr_illegal !== 1'b0) begin
      errors++; $display("FAIL ill_word1: got i=%h ill=%b want 00000013/0", instr, instr_illegal);
    end
    @(negedge clk);
    checks++;
    if (instr_illegal !== 1'b0) begin
      errors++; $display("FAIL ill_empty: got %b want 0", instr_illegal);
    end
    instr_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_redirect_midline();
    test_backpressure();
    test_redirect_wait();
    test_push_pop();
    test_reset_mid_wait();
`ifdef FETCH_ILLEGAL_EN
    test_illegal();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unpacker.md
FETCH_UNPACKER -- requirements
Module: fetch_unpacker

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_0000, fetch PC loaded at reset.
REQ-002 SHALL have parameter DEPTH, default 4, instruction FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port redirect, input, 1, flush and restart fetch at redirect_pc.
REQ-006 SHALL have port redirect_pc, input, 64, new fetch PC; bits [1:0] ignored (treated as 0).
REQ-007 SHALL have port fetch_req, output, 1, memory line request.
REQ-008 SHALL have port fetch_addr, output, 64, request address, bits [2:0] always 0.
REQ-009 SHALL have port fetch_gnt, input, 1, request accepted this cycle.
REQ-010 SHALL have port rdata_valid, input, 1, response beat present.
REQ-011 SHALL have port rdata, input, 64, response line, little-endian (word 0 = bits [31:0]).
REQ-012 SHALL have port instr_valid, output, 1, instr/instr_pc valid to decoder.
REQ-013 SHALL have port instr, output, 32, instruction word to decoder.
REQ-014 SHALL have port instr_pc, output, 64, PC of instr.
REQ-015 SHALL have port instr_ready, input, 1, decoder accepts; transfer when instr_valid && instr_ready.

Function
REQ-016 SHALL implement FSM REQ, WAIT, DROP; at most one outstanding request.
REQ-017 REQ: SHALL assert fetch_req only when free FIFO slots >= 2; fetch_gnt moves to WAIT.
REQ-018 WAIT: on rdata_valid SHALL push word 0 then word 1 (PC, PC+4) in one cycle, advance line address by 8, return to REQ.
REQ-019 If fetch PC bit 2 = 1 (line entered mid-line), SHALL push only word 1 for that line.
REQ-020 FIFO SHALL accept up to 2 pushes and 1 pop in the same cycle; count = count + pushes - pop, never exceeding DEPTH.
REQ-021 instr/instr_pc SHALL present the FIFO head combinationally; instr_valid = FIFO non-empty.
REQ-022 Outputs SHALL hold stable while instr_valid && !instr_ready.
REQ-023 Redirect: SHALL empty FIFO that edge (any same-cycle pop/push discarded); fetch PC <= redirect_pc.
REQ-024 Redirect in REQ: SHALL stay REQ; fetch_addr reflects new PC next cycle (ungranted request withdrawn).
REQ-025 Redirect in WAIT, or in REQ coinciding with fetch_gnt: SHALL go DROP; next rdata_valid discarded, then REQ.
REQ-026 Redirect in DROP: SHALL update PC, stay DROP.
REQ-027 Minimum latency fetch_gnt -> instr_valid: rdata_valid cycle + 1.
REQ-028 rdata_valid in REQ SHALL be ignored.

Reset
REQ-029 On reset: state REQ, fetch PC = RESET_PC, FIFO empty, instr_valid 0, fetch_req 0 in reset cycle, instr 0, instr_pc 0 when empty.
REQ-030 Reset mid-WAIT SHALL abandon the request; a later rdata_valid in REQ is ignored per REQ-028.

Configuration
REQ-031 Macro FETCH_ILLEGAL_EN: when defined, SHALL add output instr_illegal (1) = instr_valid && instr[1:0] != 2'b11, stored per entry; when undefined, port absent, no extra storage.

Verification
REQ-032 Reset, RESET_PC=0x1000, gnt immediate, rdata=0x00500093_00000013 -> instr 0x00000013 @0x1000, then 0x00500093 @0x1004.
REQ-033 Redirect to 0x2004 -> fetch_addr 0x2000; only upper word emitted, instr_pc 0x2004; next line 0x2008.
REQ-034 instr_ready=0 with DEPTH=4 -> after 2 lines fetch_req stays 0; FIFO count 4, head unchanged.
REQ-035 Redirect to 0x3000 while in WAIT -> returning line dropped, instr_valid 0, next fetch_addr 0x3000.
REQ-036 Push 2 + pop 1 same cycle at count 2 -> count 3, order preserved.
REQ-037 FETCH_ILLEGAL_EN defined, rdata word 0 = 0x00000001 -> instr_illegal 1 for that entry only.
